// File: rtl/sl_tx_scheduler.sv
// Round-robin arbiter feeding a single SL two-wire serialiser (LSB first, odd parity).
// Lines idle high; bit 0 pulses sl0 low, bit 1 pulses sl1 low, both low marks end of word.
module sl_tx_scheduler #(
   parameter int NUM_REQ   = 2,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 4,
   parameter int STOP_LEN  = 8,
   parameter int IDLE_LEN  = 8,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*32-1:0]   req_data,
   input  logic [NUM_REQ*5-1:0]    req_len,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    sl0,
   output logic                    sl1,
   output logic                    busy,
   output logic                    done,
   output logic [ID_W-1:0]         done_id
);

   typedef enum logic [2:0] {
      S_IDLE, S_PULSE, S_GAP, S_STOP, S_RECOVER
   } state_t;

   localparam logic [15:0] PULSE_RL = 16'(PULSE_LEN - 1);
   localparam logic [15:0] GAP_RL   = 16'(GAP_LEN - 1);
   localparam logic [15:0] STOP_RL  = 16'(STOP_LEN - 1);
   localparam logic [15:0] IDLE_RL  = 16'(IDLE_LEN - 1);

   state_t            state_q, state_nx;
   logic [15:0]       cnt_q, cnt_nx;
   logic [5:0]        bit_q, bit_nx;
   logic [31:0]       data_q;
   logic [4:0]        len_q;
   logic              par_q;
   logic [ID_W-1:0]   gid_q;
   logic [ID_W-1:0]   ptr_q;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [31:0]       win_data;
   logic [4:0]        win_len;
   logic [31:0]       win_masked;
   logic              win_par;
   logic              accept;

   logic [31:0]       data_sel;
   logic [4:0]        len_sel;
   logic              par_sel;
   logic              bit_val;
   logic              last_bit;
   logic              sl0_nx, sl1_nx, busy_nx, done_nx;

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         if (!win_found && req_valid[(int'(ptr_q) + off) % NUM_REQ]) begin
            win_found = 1'b1;
            win_idx   = ID_W'((int'(ptr_q) + off) % NUM_REQ);
         end
      end
      win_data = req_data[int'(win_idx)*32 +: 32];
      win_len  = req_len[int'(win_idx)*5 +: 5];
      win_masked = '0;
      for (int i = 0; i < 32; i++) begin
         win_masked[i] = win_data[i] & (5'(i) <= win_len);
      end
      win_par   = ~^win_masked;
      accept    = (state_q == S_IDLE) && enable && win_found;
      req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
   end

   assign last_bit = (bit_q == ({1'b0, len_q} + 6'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_nx;
         cnt_q   <= cnt_nx;
         bit_q   <= bit_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      bit_nx   = bit_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_nx = S_PULSE;
               cnt_nx   = PULSE_RL;
               bit_nx   = '0;
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_nx = S_GAP;
               cnt_nx   = GAP_RL;
            end else begin
               cnt_nx = cnt_q - 16'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               if (last_bit) begin
                  state_nx = S_STOP;
                  cnt_nx   = STOP_RL;
               end else begin
                  state_nx = S_PULSE;
                  cnt_nx   = PULSE_RL;
                  bit_nx   = bit_q + 6'd1;
               end
            end else begin
               cnt_nx = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               state_nx = S_RECOVER;
               cnt_nx   = IDLE_RL;
            end else begin
               cnt_nx = cnt_q - 16'd1;
            end
         end
         S_RECOVER: begin
            if (cnt_q == '0) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_q - 16'd1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Outputs are computed from the next state so the registered lines line up with the phase.
   always_comb begin
      data_sel = accept ? win_data : data_q;
      len_sel  = accept ? win_len  : len_q;
      par_sel  = accept ? win_par  : par_q;
      bit_val  = (bit_nx == ({1'b0, len_sel} + 6'd1)) ? par_sel : data_sel[bit_nx[4:0]];
      sl0_nx   = 1'b1;
      sl1_nx   = 1'b1;
      case (state_nx)
         S_PULSE: begin
            if (bit_val) sl1_nx = 1'b0;
            else         sl0_nx = 1'b0;
         end
         S_STOP: begin
            sl0_nx = 1'b0;
            sl1_nx = 1'b0;
         end
         default: ;
      endcase
      busy_nx = (state_nx != S_IDLE);
      done_nx = (state_nx == S_RECOVER) && (cnt_nx == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sl0     <= 1'b1;
         sl1     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         data_q  <= '0;
         len_q   <= '0;
         par_q   <= 1'b0;
         gid_q   <= '0;
         ptr_q   <= '0;
      end else begin
         sl0  <= sl0_nx;
         sl1  <= sl1_nx;
         busy <= busy_nx;
         done <= done_nx;
         if (done_nx) done_id <= gid_q;
         if (accept) begin
            data_q <= win_data;
            len_q  <= win_len;
            par_q  <= win_par;
            gid_q  <= win_idx;
            ptr_q  <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sl_tx_scheduler.sv
// Directed bench for sl_tx_scheduler with a line-decoding SL receiver model.
module tb_sl_tx_scheduler;
   logic        clk, rst, enable;
   logic [1:0]  req_valid;
   logic [63:0] req_data;
   logic [9:0]  req_len;
   logic [1:0]  req_ready;
   logic        sl0, sl1, busy, done;
   logic [0:0]  done_id;

   sl_tx_scheduler #(
      .NUM_REQ(2), .PULSE_LEN(2), .GAP_LEN(2), .STOP_LEN(4), .IDLE_LEN(4)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid),
      .req_data(req_data), .req_len(req_len), .req_ready(req_ready),
      .sl0(sl0), .sl1(sl1), .busy(busy), .done(done), .done_id(done_id)
   );

   int n_assert = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Receiver model and event logs, sampled on the falling edge.
   logic        p0 = 1'b1, p1 = 1'b1;
   int          rx_n = 0, last_n = 0;
   logic [63:0] rx_vec = '0, last_vec = '0;
   int          busy_run = 0, last_busy = 0;
   int          done_total = 0, onehot_bad = 0;
   int          grants[$];
   int          done_ids[$];

   always @(negedge clk) begin
      if (rst) begin
         rx_n = 0; rx_vec = '0;
      end else if (!sl0 && !sl1 && !(!p0 && !p1)) begin
         last_n = rx_n; last_vec = rx_vec; rx_n = 0; rx_vec = '0;
      end else if (!sl0 && sl1 && p0 && p1 && rx_n < 64) begin
         rx_vec[rx_n] = 1'b0; rx_n++;
      end else if (sl0 && !sl1 && p0 && p1 && rx_n < 64) begin
         rx_vec[rx_n] = 1'b1; rx_n++;
      end
      p0 = sl0; p1 = sl1;
      if (busy) busy_run++;
      else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
      if (done) begin done_ids.push_back(int'(done_id)); done_total++; end
      if (|(req_valid & req_ready)) begin
         if ($countones(req_ready) != 1) onehot_bad++;
         for (int i = 0; i < 2; i++) if (req_ready[i]) grants.push_back(i);
      end
   end

   function automatic logic [63:0] rx_data();
      return last_vec & ((64'd1 << (last_n - 1)) - 64'd1);
   endfunction

   function automatic logic rx_parity_valid();
      int ones;
      ones = 0;
      for (int i = 0; i < last_n; i++) if (last_vec[i]) ones++;
      return (ones % 2 == 1) && ((last_n - ones) % 2 == 0);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int limit);
      logic got;
      got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(posedge clk); #1;
         if (done) got = 1'b1;
      end
      check("done_within_budget", 64'(got), 64'd1);
   endtask

   initial begin
      int g0, d0;
      rst = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0; req_len = '0;
      #2;
      check("rst_sl0", 64'(sl0), 64'd1);
      check("rst_sl1", 64'(sl1), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_done_id", 64'(done_id), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      tick(2);
      rst = 1'b0;

      // Single 8-bit word from requester 0
      enable = 1'b1; req_data[31:0] = 32'h000000A5; req_len[4:0] = 5'd7; req_valid = 2'b01;
      #1;
      check("t1_ready", 64'(req_ready), 64'h1);
      tick(1);
      req_valid = 2'b00;
      check("t1_busy_on", 64'(busy), 64'd1);
      check("t1_first_sl1", 64'(sl1), 64'd0);
      check("t1_first_sl0", 64'(sl0), 64'd1);
      wait_done(200);
      check("t1_done_id", 64'(done_id), 64'd0);
      tick(2);
      check("t1_rx_bits", 64'(last_n), 64'd9);
      check("t1_rx_order", last_vec, 64'h1A5);
      check("t1_rx_data", rx_data(), 64'hA5);
      check("t1_rx_bitcount", 64'(last_n - 1), 64'd8);
      check("t1_rx_parity", 64'(rx_parity_valid()), 64'd1);
      check("t1_busy_len", 64'(last_busy), 64'd44);

      // Full 32-bit word from requester 1
      req_data[63:32] = 32'hFFFFFFFF; req_len[9:5] = 5'd31; req_valid = 2'b10;
      #1;
      check("t2_ready", 64'(req_ready), 64'h2);
      tick(1);
      req_valid = 2'b00;
      wait_done(400);
      check("t2_done_id", 64'(done_id), 64'd1);
      tick(2);
      check("t2_rx_bits", 64'(last_n), 64'd33);
      check("t2_rx_data", rx_data(), 64'hFFFFFFFF);
      check("t2_rx_parity_bit", 64'(last_vec[32]), 64'd1);
      check("t2_rx_parity", 64'(rx_parity_valid()), 64'd1);
      check("t2_busy_len", 64'(last_busy), 64'd140);

      // Arbitration with both requesters held valid from reset
      rst = 1'b1; tick(1); rst = 1'b0;
      grants.delete(); done_ids.delete(); onehot_bad = 0;
      req_data = {32'h00000001, 32'h00000000}; req_len = '0; req_valid = 2'b11;
      for (int k = 0; k < 4; k++) wait_done(100);
      req_valid = 2'b00;
      tick(5);
      check("t3_grant_count", 64'(grants.size()), 64'd4);
      check("t3_done_count", 64'(done_ids.size()), 64'd4);
      for (int k = 0; k < 4 && k < grants.size() && k < done_ids.size(); k++) begin
         check($sformatf("t3_grant%0d", k), 64'(grants[k]), 64'(k % 2));
         check($sformatf("t3_done_id%0d", k), 64'(done_ids[k]), 64'(k % 2));
      end
      check("t3_onehot", 64'(onehot_bad), 64'd0);

      // Reset during the pulse of bit 3
      req_data[31:0] = 32'h0000000F; req_len[4:0] = 5'd7; req_valid = 2'b01;
      #1;
      check("t4_ready", 64'(req_ready), 64'h1);
      tick(1);
      req_valid = 2'b00;
      tick(12);
      check("t4_bit3_sl1", 64'(sl1), 64'd0);
      check("t4_bit3_busy", 64'(busy), 64'd1);
      d0 = done_total;
      rst = 1'b1;
      #1;
      check("t4_rst_sl0", 64'(sl0), 64'd1);
      check("t4_rst_sl1", 64'(sl1), 64'd1);
      check("t4_rst_busy", 64'(busy), 64'd0);
      tick(3);
      rst = 1'b0; req_valid = 2'b11;
      #1;
      check("t4_ptr_reset_ready", 64'(req_ready), 64'h1);
      check("t4_no_done", 64'(done_total), 64'(d0));
      tick(1);
      req_valid = 2'b00;
      wait_done(200);
      check("t4_done_id", 64'(done_id), 64'd0);
      tick(2);

      // enable gating
      enable = 1'b0; req_data[31:0] = 32'h00000003; req_len[4:0] = 5'd1; req_valid = 2'b01;
      g0 = grants.size();
      tick(5);
      check("t5_blocked_ready", 64'(req_ready), 64'd0);
      check("t5_blocked_lines", 64'({sl0, sl1}), 64'h3);
      check("t5_blocked_busy", 64'(busy), 64'd0);
      enable = 1'b1;
      #1;
      check("t5_enable_ready", 64'(req_ready), 64'h1);
      tick(1);
      check("t5_busy", 64'(busy), 64'd1);
      tick(2);
      check("t5_gap_lines", 64'({sl0, sl1}), 64'h3);
      enable = 1'b0;
      wait_done(200);
      check("t5_done_id", 64'(done_id), 64'd0);
      tick(10);
      check("t5_idle_busy", 64'(busy), 64'd0);
      check("t5_idle_ready", 64'(req_ready), 64'd0);
      check("t5_single_grant", 64'(grants.size()), 64'(g0 + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
